// File: rtl/regfile_pkg.sv
// Shared widths, limits, state encoding and write payload for the register file write arbiter.
package regfile_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NREGS    = 32;
  localparam int unsigned MAX_WAIT = 8;
  localparam int unsigned WAIT_W   = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] pd;
  } wr_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester handshakes, clear request and register file write port of the write arbiter.
interface regfile_write_arbiter_if;
  import regfile_pkg::*;

  logic              p_valid;
  logic [ADDR_W-1:0] p_rd;
  logic [DATA_W-1:0] p_pd;
  logic              p_ready;
  logic              d_valid;
  logic [ADDR_W-1:0] d_rd;
  logic [DATA_W-1:0] d_pd;
  logic              d_ready;
  logic              clr_req;
  logic              busy;
  logic              en;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] pd;

  // Requesters and observers of the register file port
  modport master (
    output p_valid, p_rd, p_pd, d_valid, d_rd, d_pd, clr_req,
    input  p_ready, d_ready, busy, en, rd, pd
  );

  modport slave (
    input  p_valid, p_rd, p_pd, d_valid, d_rd, d_pd, clr_req,
    output p_ready, d_ready, busy, en, rd, pd
  );

endinterface

// File: rtl/rf_clear_seq.sv
// Clear sequencer: walks the register index 1..NREGS-1 one step per cycle while stepping.
module rf_clear_seq
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  output logic [ADDR_W-1:0] idx,
  output logic              done_c
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NREGS - 1);

  // Final step of a pass; the arbiter leaves CLEAR on the same edge
  assign done_c = step && (idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= FIRST_IDX;
    end else if (start || done_c) begin
      idx <= FIRST_IDX;
    end else if (step) begin
      idx <= idx + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register file write port: arbitrates pipeline (P) and debug (D) writers and
// runs the R1..R31 clear sequence, with a registered write port one cycle after accept.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_write_arbiter_if.slave  bus
);

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              en_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] pd_q;

  logic              open_c;
  logic              d_turn_c;
  logic              p_acc_c;
  logic              d_acc_c;
  logic              start_c;
  logic              step_c;
  logic              clr_done_c;
  logic [ADDR_W-1:0] clr_idx;
  wr_t               win_c;

  // Arbitration: P has priority until D has starved MAX_WAIT cycles
  assign open_c   = (state == RUN) && !bus.clr_req && !rst;
  assign d_turn_c = (wait_cnt == WAIT_LIMIT);

  assign bus.p_ready = open_c && !(d_turn_c && bus.d_valid);
  assign bus.d_ready = open_c && (d_turn_c || !bus.p_valid);

  assign p_acc_c = bus.p_valid && bus.p_ready;
  assign d_acc_c = bus.d_valid && bus.d_ready;

  assign start_c = (state == RUN) && bus.clr_req;
  assign step_c  = (state == CLEAR);

  always_comb begin
    win_c = '{rd: bus.d_rd, pd: bus.d_pd};
    if (p_acc_c) begin
      win_c = '{rd: bus.p_rd, pd: bus.p_pd};
    end
  end

  rf_clear_seq u_clear_seq (
    .clk    (clk),
    .rst    (rst),
    .start  (start_c),
    .step   (step_c),
    .idx    (clr_idx),
    .done_c (clr_done_c)
  );

  // State, starvation counter and the registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RESET_STATE;
      wait_cnt <= '0;
      en_q     <= 1'b0;
      rd_q     <= '0;
      pd_q     <= '0;
    end else begin
      en_q <= 1'b0;

      if (bus.d_valid && !d_acc_c) begin
        wait_cnt <= d_turn_c ? wait_cnt : wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end

      case (state)
        CLEAR: begin
          en_q <= 1'b1;
          rd_q <= clr_idx;
          pd_q <= '0;
          if (clr_done_c) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (bus.clr_req) begin
            state <= CLEAR;
          end else if (p_acc_c || d_acc_c) begin
            // R0 is hard-wired zero: the address/data still load, the strobe does not
            en_q <= (win_c.rd != '0);
            rd_q <= win_c.rd;
            pd_q <= win_c.pd;
          end
        end
        default: state <= RESET_STATE;
      endcase
    end
  end

  assign bus.busy = (state == CLEAR);
  assign bus.en   = en_q;
  assign bus.rd   = rd_q;
  assign bus.pd   = pd_q;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port (PD, RD, EN) of the 32x32 register file.
- Arbitrates between two write requesters: the pipeline write-back stage (P) and the debug/loader port (D). Both use valid/ready handshakes.
- Contains a clear sequencer that zeroes R1..R31 after reset and on software request.
- Drives the register file write port from registered outputs, so there is exactly one cycle from accept to write.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width.
- NREGS, 32, number of registers; R0 is hard-wired zero.
- MAX_WAIT, 8, cycles a stalled D request may wait before it is forced a grant.
- CLEAR_ON_RESET, 1, when 1 the block enters CLEAR after reset; when 0 it enters RUN.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- P_VALID  in  1  pipeline write request.
- P_RD  in  ADDR_W  pipeline destination register.
- P_PD  in  DATA_W  pipeline write data.
- P_READY  out  1  pipeline request accepted this cycle when P_VALID is also high.
- D_VALID  in  1  debug write request.
- D_RD  in  ADDR_W  debug destination register.
- D_PD  in  DATA_W  debug write data.
- D_READY  out  1  debug request accepted this cycle when D_VALID is also high.
- CLR_REQ  in  1  single-cycle request to re-clear R1..R31.
- BUSY  out  1  high while state is CLEAR.
- EN  out  1  register file write enable (registered).
- RD  out  ADDR_W  register file write address (registered).
- PD  out  DATA_W  register file write data (registered).

Behaviour:
- Clock and reset: one clock, CLK. Reset is RST, asynchronous and active-high.
- Reset values:
  - EN=0, RD=0, PD=0, wait_cnt=0, clear index=1.
  - State is CLEAR if CLEAR_ON_RESET=1, otherwise RUN. BUSY follows the state.
  - P_READY and D_READY are 0 while RST is high.
- Handshake:
  - A request is accepted in any cycle where VALID and READY are both high.
  - READY is combinational from state, CLR_REQ, the other VALID and wait_cnt. It never depends on its own VALID.
  - VALID, RD and PD must be held stable until accepted.
- Output timing:
  - An accept in cycle N gives EN=1 with the accepted RD/PD in cycle N+1. The register file write occurs at the end of N+1.
  - In a cycle with no accept and no clear step, EN=0 and RD/PD hold their last values.
- State CLEAR:
  - Both READY outputs are 0.
  - Each cycle the output register is loaded with EN=1, RD=idx, PD=0, then idx increments.
  - The edge that loads idx=31 also moves the state to RUN and resets idx to 1.
  - After reset release, the register file sees exactly 31 consecutive writes, to R1..R31 in order.
  - RST asserted mid-clear restarts the sequence from R1.
- State RUN, arbitration:
  - Default: P wins. P_READY=1 and D_READY = !P_VALID.
  - When wait_cnt==MAX_WAIT, D wins for that cycle: D_READY=1 and P_READY = !D_VALID.
  - Exactly one request is accepted per cycle; two simultaneous accepts are impossible.
- wait_cnt:
  - Increments when D_VALID=1 and D is not accepted, saturating at MAX_WAIT.
  - Clears to 0 when D is accepted or when D_VALID=0.
- CLR_REQ in RUN:
  - Forces both READY outputs to 0 in that cycle.
  - The state enters CLEAR at the next edge.
  - A write already in the output register completes normally. Clear steps start the cycle after.
- CLR_REQ in CLEAR: ignored; the sequence is not restarted.
- Writes to R0: accepted normally (READY handshake completes), but EN stays 0 in the following cycle. RD and PD are still updated.

Decomposition:
- Package regfile_pkg holds DATA_W, ADDR_W, NREGS, MAX_WAIT and the state enum {CLEAR, RUN}.
- One sub-module, rf_clear_seq, contains:
  - the index counter and its 1..31 wrap;
  - the start/done handshake with the arbiter FSM.
- The arbiter, the wait counter and the output register stay in the top module.

Test Plan:
- Reset release with CLEAR_ON_RESET=1 -> BUSY=1; EN=1 for 31 cycles with RD=1..31 in order and PD=0; then BUSY=0; P_READY=D_READY=0 throughout the clear.
- RUN, P_VALID with P_RD=5, P_PD=0xDEADBEEF accepted in cycle N -> cycle N+1 shows EN=1, RD=5, PD=0xDEADBEEF; cycle N+2 shows EN=0.
- P_VALID and D_VALID both held high for 12 cycles, MAX_WAIT=8 -> P accepted in cycles 0-7; D_READY=1 and P_READY=0 in cycle 8; P accepted again in cycles 9-11; wait_cnt=0 after the D accept.
- P_VALID with P_RD=0, P_PD=0x1234 -> P_READY=1; next cycle EN=0, RD=0, PD=0x1234.
- CLR_REQ pulse in the same cycle as P_VALID -> P not accepted in that cycle; BUSY=1 next cycle; 31-step clear follows; P is accepted only after BUSY falls.
- RST asserted while the clear is at RD=17 -> EN=0 and RD=0 immediately (asynchronous); after release the clear restarts at RD=1.
